sbox_sched: RTL and testbench

//  Sequences the chaotic S-box builder (sbox) and then uses its result for pixel substitution.

---
 rtl/sbox_pkg.sv | 18 +
 rtl/sbox_sched_if.sv | 13 +
 rtl/sbox_table_ram.sv | 36 +++
 rtl/sbox_sched.sv | 183 ++++++++++++++++++
 tb/tb_sbox_sched.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sbox_pkg.sv
// Shared types and constants for the S-box sequencer.
// Imported by the table RAM, the stream interface and the sequencer.
package sbox_pkg;

    localparam int SBOX_SIZE = 256;
    localparam int BYTE_W    = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [2:0] {
        IDLE,
        SBRST,
        BUILD,
        SUBST,
        ERR
    } state_t;

endpackage

// File: rtl/sbox_sched_if.sv
// Byte stream with valid/ready handshake.
// Used for the pixel input and the substituted output.
interface sbox_sched_if;
    import sbox_pkg::*;

    logic  valid;
    byte_t data;
    logic  ready;

    modport master (output valid, data, input ready);
    modport slave  (input valid, data, output ready);

endinterface

// File: rtl/sbox_table_ram.sv
// Forward (S) and inverse (Si) substitution tables.
// Independent write ports, one shared registered read port.
module sbox_table_ram
    import sbox_pkg::*;
(
    input  logic  clk,
    input  logic  s_we,
    input  byte_t s_addr,
    input  byte_t s_wdata,
    input  logic  si_we,
    input  byte_t si_addr,
    input  byte_t si_wdata,
    input  logic  rd_sel,
    input  byte_t rd_addr,
    output byte_t rd_data
);

    byte_t s_mem  [SBOX_SIZE];
    byte_t si_mem [SBOX_SIZE];

    // forward table write
    always_ff @(posedge clk) begin
        if (s_we) s_mem[s_addr] <= s_wdata;
    end

    // inverse table write
    always_ff @(posedge clk) begin
        if (si_we) si_mem[si_addr] <= si_wdata;
    end

    // one-cycle read, rd_sel picks the inverse table
    always_ff @(posedge clk) begin
        rd_data <= rd_sel ? si_mem[rd_addr] : s_mem[rd_addr];
    end

endmodule

// File: rtl/sbox_sched.sv
// Builds the chaotic S-box via the external builder, then streams
// pixels through the forward or inverse table.
module sbox_sched
    import sbox_pkg::*;
#(
    parameter int N_PIXELS  = 65536,
    parameter int SB_GAP    = 2,
    parameter int BUILD_TMO = 4096
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         mode,
    output logic         busy,
    output logic         done,
    output logic         err,
    input  logic         chaos_valid,
    input  byte_t        chaos_byte,
    output logic         chaos_ready,
    output logic         sb_reset_n,
    output logic         sb_tvalid,
    output byte_t        sb_v,
    input  logic         sb_valid,
    input  byte_t        sb_v_out,
    input  logic         sb_done,
    sbox_sched_if.slave  pix_in,
    sbox_sched_if.master pix_out
);

    localparam int PW = $clog2(N_PIXELS + 1);
    localparam int TW = $clog2(BUILD_TMO + 1);
    localparam int GW = $clog2(SB_GAP + 1);

    localparam logic [PW-1:0] PIX_MAX  = PW'(N_PIXELS);
    localparam logic [PW-1:0] PIX_LAST = PW'(N_PIXELS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(BUILD_TMO - 1);
    localparam logic [GW-1:0] GAP_MAX  = GW'(SB_GAP - 1);
    localparam logic [8:0]    INS_LAST = 9'(SBOX_SIZE - 1);

    state_t          state, state_n;
    logic            mode_r;
    logic [GW-1:0]   gap;
    logic [8:0]      ins;
    logic [TW-1:0]   tmo;
    logic [PW-1:0]   pix_cnt, out_cnt;
    logic            rd_v, skid_v;
    byte_t           skid_d, rd_data;
    logic            go, consume, ins_we, ins_last;
    logic            accept, drain, last_out;

    assign go       = start && (state == IDLE || state == ERR);
    assign consume  = chaos_valid && chaos_ready;
    assign ins_we   = (state == BUILD) && sb_valid;
    assign ins_last = ins_we && (ins == INS_LAST);
    assign accept   = pix_in.valid && pix_in.ready;
    assign drain    = pix_out.valid && pix_out.ready;
    assign last_out = (state == SUBST) && drain && (out_cnt == PIX_LAST);

    assign busy        = (state != IDLE) && (state != ERR);
    assign sb_reset_n  = (state != SBRST);
    assign chaos_ready = (state == BUILD) && (gap >= GAP_MAX);

    // a read in flight needs a free slot if the output stays stalled
    assign pix_in.ready = (state == SUBST) && (pix_cnt != PIX_MAX) &&
                          !skid_v &&
                          !(rd_v && pix_out.valid && !pix_out.ready);

    sbox_table_ram u_tab (
        .clk      (clk),
        .s_we     (ins_we),
        .s_addr   (ins[7:0]),
        .s_wdata  (sb_v_out),
        .si_we    (ins_we),
        .si_addr  (sb_v_out),
        .si_wdata (ins[7:0]),
        .rd_sel   (mode_r),
        .rd_addr  (pix_in.data),
        .rd_data  (rd_data)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // next state; completing the box wins over done/timeout
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (start) state_n = SBRST;
            SBRST: state_n = BUILD;
            BUILD: begin
                if (ins_last)                      state_n = SUBST;
                else if (sb_done || tmo == TMO_LAST) state_n = ERR;
            end
            SUBST: if (last_out) state_n = IDLE;
            ERR:   if (start) state_n = SBRST;
            default: state_n = IDLE;
        endcase
    end

    // mode capture, sticky error and done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_r <= 1'b0;
            err    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= last_out;
            if (go) begin
                mode_r <= mode;
                err    <= 1'b0;
            end else if (state == BUILD && state_n == ERR) begin
                err <= 1'b1;
            end
        end
    end

    // chaos byte pacing towards the builder
    always_ff @(posedge clk) begin
        if (reset) begin
            gap       <= '0;
            sb_tvalid <= 1'b0;
            sb_v      <= '0;
        end else begin
            sb_tvalid <= consume;
            if (consume) sb_v <= chaos_byte;
            if (state == SBRST)     gap <= GAP_MAX;
            else if (consume)       gap <= '0;
            else if (gap < GAP_MAX) gap <= gap + 1'b1;
        end
    end

    // insert index and build watchdog
    always_ff @(posedge clk) begin
        if (reset || state == SBRST) begin
            ins <= '0;
            tmo <= '0;
        end else if (state == BUILD) begin
            tmo <= tmo + 1'b1;
            if (ins_we) ins <= ins + 9'd1;
        end
    end

    // substitution pipeline: table read, output register, skid slot
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_v          <= 1'b0;
            skid_v        <= 1'b0;
            skid_d        <= '0;
            pix_out.valid <= 1'b0;
            pix_out.data  <= '0;
            pix_cnt       <= '0;
            out_cnt       <= '0;
        end else if (state != SUBST) begin
            rd_v          <= 1'b0;
            skid_v        <= 1'b0;
            pix_out.valid <= 1'b0;
            pix_cnt       <= '0;
            out_cnt       <= '0;
        end else begin
            rd_v <= accept;
            if (accept) pix_cnt <= pix_cnt + 1'b1;
            if (drain)  out_cnt <= out_cnt + 1'b1;
            if (drain || !pix_out.valid) begin
                if (skid_v) begin
                    pix_out.valid <= 1'b1;
                    pix_out.data  <= skid_d;
                    skid_v        <= rd_v;
                    skid_d        <= rd_data;
                end else begin
                    pix_out.valid <= rd_v;
                    if (rd_v) pix_out.data <= rd_data;
                end
            end else if (rd_v) begin
                skid_v <= 1'b1;
                skid_d <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_sbox_sched.sv
// Scoreboard bench for sbox_sched with a behavioural builder model.
// Directed frames: build orders, modes, stalls, error and abort cases.
module tb_sbox_sched;
    import sbox_pkg::*;

    localparam int NPIX = 256;

    logic  clk = 1'b0;
    logic  reset, start, mode;
    logic  busy, done, err;
    logic  chaos_valid, chaos_ready;
    byte_t chaos_byte;
    logic  sb_reset_n, sb_tvalid, sb_valid, sb_done;
    byte_t sb_v, sb_v_out;

    sbox_sched_if pin_if ();
    sbox_sched_if pout_if ();

    int    checks = 0;
    int    errors = 0;
    byte_t exp_q[$];
    int    bm_order = 0;
    int    bm_limit = 256;
    bit    bm_done_en = 1'b1;
    bit    rnd_ready = 1'b0;
    int    done_cnt = 0;
    int    mon_outs = 0;

    always #5 clk = ~clk;

    sbox_sched #(
        .N_PIXELS  (NPIX),
        .SB_GAP    (2),
        .BUILD_TMO (4096)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mode        (mode),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .chaos_valid (chaos_valid),
        .chaos_byte  (chaos_byte),
        .chaos_ready (chaos_ready),
        .sb_reset_n  (sb_reset_n),
        .sb_tvalid   (sb_tvalid),
        .sb_v        (sb_v),
        .sb_valid    (sb_valid),
        .sb_v_out    (sb_v_out),
        .sb_done     (sb_done),
        .pix_in      (pin_if.slave),
        .pix_out     (pout_if.master)
    );

    task automatic chk1(input string nm, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, a, e);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] a, input logic [7:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    task automatic chki(input string nm, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    // value the builder model inserts at position k
    function automatic int order_val(input int ord, input int k);
        case (ord)
            1:       return 255 - k;
            2:       return (k + 1) & 255;
            default: return k;
        endcase
    endfunction

    // hand-derived S[p] / Si[p] for each build order
    function automatic int expv(input int ord, input bit md, input int p);
        if (ord == 2) return md ? ((p + 255) & 255) : ((p + 1) & 255);
        if (ord == 1) return 255 - p;
        return p;
    endfunction

    function automatic int pixel(input int pat, input int i);
        if (pat == 0) return i;
        if (i == 0)   return 0;
        if (i == 1)   return 1;
        if (i == 2)   return 255;
        return (i * 37 + 11) & 255;
    endfunction

    task automatic check_reset_vals(input string p);
        chk1({p, "_busy"}, busy, 1'b0);
        chk1({p, "_done"}, done, 1'b0);
        chk1({p, "_err"}, err, 1'b0);
        chk1({p, "_chaos_ready"}, chaos_ready, 1'b0);
        chk1({p, "_sb_tvalid"}, sb_tvalid, 1'b0);
        chk1({p, "_sb_reset_n"}, sb_reset_n, 1'b1);
        chk8({p, "_sb_v"}, sb_v, 8'd0);
        chk1({p, "_pix_ready"}, pin_if.ready, 1'b0);
        chk1({p, "_out_valid"}, pout_if.valid, 1'b0);
        chk8({p, "_out_data"}, pout_if.data, 8'd0);
    endtask

    // start pulse; builder reset must be low for exactly one cycle
    task automatic start_frame(input int ord, input bit md, input int lim, input bit den);
        bm_order   = ord;
        bm_limit   = lim;
        bm_done_en = den;
        @(posedge clk); #1;
        start = 1'b1;
        mode  = md;
        @(posedge clk); #1;
        start = 1'b0;
        chk1("sbrst_low", sb_reset_n, 1'b0);
        chk1("err_clear", err, 1'b0);
        chk1("sbrst_busy", busy, 1'b1);
        @(posedge clk); #1;
        chk1("sbrst_high", sb_reset_n, 1'b1);
    endtask

    task automatic run_frame(input int ord, input bit md, input int pat,
                             input bit rnd, input int abort_at);
        int n;
        int d0;
        rnd_ready = rnd;
        start_frame(ord, md, 256, 1'b1);
        d0 = done_cnt;
        n  = 0;
        while (!pin_if.ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk1("subst_entry", pin_if.ready, 1'b1);
        for (int i = 0; i < NPIX; i++) begin
            if (i == abort_at) break;
            pin_if.valid = 1'b1;
            pin_if.data  = 8'(pixel(pat, i));
            @(negedge clk);
            n = 0;
            while (!pin_if.ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!pin_if.ready) begin
                chk1("pix_accept", pin_if.ready, 1'b1);
                break;
            end
            exp_q.push_back(8'(expv(ord, md, pixel(pat, i))));
            @(posedge clk); #1;
        end
        pin_if.valid = 1'b0;
        if (abort_at >= 0) begin
            reset = 1'b1;
            @(posedge clk); #1;
            check_reset_vals("abort");
            reset = 1'b0;
            exp_q.delete();
            repeat (50) @(posedge clk);
            #1;
            chki("abort_no_done", done_cnt, d0);
        end else begin
            n = 0;
            while (done_cnt == d0 && n < 3000) begin
                @(posedge clk); #1;
                n++;
            end
            chki("done_seen", done_cnt, d0 + 1);
            chki("queue_empty", exp_q.size(), 0);
            repeat (3) @(posedge clk);
            #1;
            chki("done_once", done_cnt, d0 + 1);
            chk1("idle_busy", busy, 1'b0);
        end
    endtask

    // builder model: one insert per sb_tvalid, optional sb_done at limit
    initial begin : builder
        int cnt;
        cnt      = 0;
        sb_valid = 1'b0;
        sb_v_out = '0;
        sb_done  = 1'b0;
        forever begin
            @(posedge clk); #1;
            sb_valid = 1'b0;
            if (reset || !sb_reset_n) begin
                cnt     = 0;
                sb_done = 1'b0;
            end else if (sb_tvalid && cnt < bm_limit) begin
                sb_valid = 1'b1;
                sb_v_out = 8'(order_val(bm_order, cnt));
                cnt++;
                if (cnt == bm_limit && bm_done_en) sb_done = 1'b1;
            end
        end
    end

    // downstream ready and chaos byte source
    initial begin : sources
        pout_if.ready = 1'b1;
        chaos_byte    = '0;
        forever begin
            @(posedge clk); #1;
            pout_if.ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            chaos_byte    = chaos_byte + 8'd1;
        end
    end

    // output monitor: scoreboard pop, stall stability, done position
    initial begin : monitor
        bit    stalled;
        byte_t held;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stalled = 1'b0;
            end else begin
                if (!sb_reset_n) mon_outs = 0;
                if (stalled) begin
                    chk1("hold_valid", pout_if.valid, 1'b1);
                    chk8("hold_data", pout_if.data, held);
                end
                if (pout_if.valid && pout_if.ready) begin
                    chk1("out_expected", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) chk8("out_data", pout_if.data, exp_q.pop_front());
                    mon_outs++;
                end
                stalled = pout_if.valid && !pout_if.ready;
                held    = pout_if.data;
                if (done) begin
                    done_cnt++;
                    chki("done_pos", mon_outs, NPIX);
                    chk1("done_busy", busy, 1'b0);
                end
            end
        end
    end

    // builder strobe spacing and forwarded byte
    initial begin : pacing
        int    cyc;
        int    last_tv;
        bit    have_last;
        byte_t want_v;
        cyc       = 0;
        last_tv   = 0;
        have_last = 1'b0;
        want_v    = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset || !sb_reset_n) begin
                have_last = 1'b0;
            end else if (sb_tvalid) begin
                chk8("sb_v", sb_v, want_v);
                if (have_last) chki("tv_gap", cyc - last_tv, 2);
                have_last = 1'b1;
                last_tv   = cyc;
            end
            if (chaos_valid && chaos_ready) want_v = chaos_byte;
        end
    end

    initial begin : main
        int n;
        reset        = 1'b1;
        start        = 1'b0;
        mode         = 1'b0;
        chaos_valid  = 1'b1;
        pin_if.valid = 1'b0;
        pin_if.data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        reset = 1'b0;

        run_frame(0, 1'b0, 0, 1'b0, -1);
        run_frame(1, 1'b1, 1, 1'b0, -1);
        run_frame(1, 1'b0, 1, 1'b1, -1);
        run_frame(2, 1'b1, 1, 1'b1, -1);
        run_frame(2, 1'b0, 1, 1'b1, 37);
        run_frame(2, 1'b0, 1, 1'b0, -1);

        start_frame(0, 1'b0, 200, 1'b1);
        n = 0;
        while (!err && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk1("early_done_err", err, 1'b1);
        chk1("err_busy", busy, 1'b0);
        chk1("err_pix_ready", pin_if.ready, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk1("err_sticky", err, 1'b1);

        run_frame(0, 1'b1, 1, 1'b1, -1);

        start_frame(0, 1'b0, 100, 1'b0);
        n = 0;
        while (!err && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        chki("tmo_cycles", n, 4096);
        chk1("tmo_err", err, 1'b1);
        chk1("tmo_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
